// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared channel/count widths and arbiter state encoding
package spectrum_pkg;
  localparam int SPEC_ADDR_W = 10;
  localparam int SPEC_DATA_W = 32;
  typedef enum logic [6:0] {
    IDLE      = 7'b0000001,
    ACQ_RD    = 7'b0000010,
    ACQ_WAIT  = 7'b0000100,
    ACQ_WR    = 7'b0001000,
    HOST_RD   = 7'b0010000,
    HOST_WAIT = 7'b0100000,
    CLEAR     = 7'b1000000
  } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin, the requester served last loses a tie
module rr_arb2 (
  input  logic CLOCK_65,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  logic prio;
  assign gnt0 = req0 && (!req1 || !prio);
  assign gnt1 = req1 && (!req0 || prio);
  // prio = 1 favours requester 1; it flips toward whoever was not just served
  always_ff @(posedge CLOCK_65 or negedge rst_n)
    if (!rst_n) prio <= 1'b0;
    else if (en && (gnt0 || gnt1)) prio <= gnt0;
endmodule

// File: rtl/spectrum_ram_arbiter.sv
// spectrum_ram_arbiter: shares one spectrum RAM between acquisition increments, host readout and clear sweeps
module spectrum_ram_arbiter
  import spectrum_pkg::*;
#(
  parameter int ADDR_W = SPEC_ADDR_W,
  parameter int DATA_W = SPEC_DATA_W
) (
  input  logic              CLOCK_65,
  input  logic              rst_n,
  input  logic              acq_req,
  input  logic [ADDR_W-1:0] acq_addr,
  output logic              acq_ack,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              sat_flag
);
  arb_state_t state;
  logic clr_pend, go_clr, arb_en, gnt_acq, gnt_host;
  assign go_clr = clr_pend || clr_req;
  assign arb_en = (state == IDLE) && !go_clr;
  rr_arb2 u_rr (
    .CLOCK_65(CLOCK_65),
    .rst_n(rst_n),
    .en(arb_en),
    .req0(acq_req),
    .req1(host_req),
    .gnt0(gnt_acq),
    .gnt1(gnt_host)
  );
  // arbiter FSM; ram_addr doubles as the latched channel and the sweep counter
  always_ff @(posedge CLOCK_65 or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      clr_pend    <= 1'b0;
      acq_ack     <= 1'b0;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      clr_busy    <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      acq_ack     <= 1'b0;
      host_ack    <= 1'b0;
      host_rvalid <= 1'b0;
      if (clr_req && state != CLEAR) clr_pend <= 1'b1;
      case (state)
        IDLE:
          if (go_clr) begin
            state     <= CLEAR;
            clr_pend  <= 1'b0;
            clr_busy  <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b1;
          end else if (gnt_acq) begin
            state    <= ACQ_RD;
            acq_ack  <= 1'b1;
            ram_addr <= acq_addr;
          end else if (gnt_host) begin
            state    <= HOST_RD;
            host_ack <= 1'b1;
            ram_addr <= host_addr;
          end
        ACQ_RD:   state <= ACQ_WAIT;
        ACQ_WAIT: begin
          state     <= ACQ_WR;
          ram_wdata <= ram_rdata + 1'b1;
          ram_we    <= !(&ram_rdata);
          if (&ram_rdata) sat_flag <= 1'b1;
        end
        ACQ_WR: begin
          state  <= IDLE;
          ram_we <= 1'b0;
        end
        HOST_RD:  state <= HOST_WAIT;
        HOST_WAIT: begin
          state       <= IDLE;
          host_rdata  <= ram_rdata;
          host_rvalid <= 1'b1;
        end
        CLEAR:
          if (&ram_addr) begin
            state    <= IDLE;
            ram_we   <= 1'b0;
            clr_busy <= 1'b0;
            sat_flag <= 1'b0;
          end else ram_addr <= ram_addr + 1'b1;
        default: begin
          state  <= IDLE;
          ram_we <= 1'b0;
        end
      endcase
    end
endmodule

// File: doc/spectrum_ram_arbiter.md
SPECTRUM_RAM_ARBITER -- requirements
Module: spectrum_ram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, channel address width; DATA_W, default 32, count width.
REQ-002 SHALL have port: CLOCK_65  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports acq_req  in  1 (acquisition increment request) and acq_addr  in  ADDR_W (channel to increment).
REQ-005 SHALL have port acq_ack  out  1: one-cycle pulse when the acquisition request is accepted.
REQ-006 SHALL have ports host_req  in  1 (host readout request) and host_addr  in  ADDR_W (channel to read).
REQ-007 SHALL have port host_ack  out  1: one-cycle pulse when the host request is accepted.
REQ-008 SHALL have ports host_rdata  out  DATA_W and host_rvalid  out  1: host read result with a one-cycle valid pulse.
REQ-009 SHALL have ports clr_req  in  1 (single-cycle clear command) and clr_busy  out  1 (clear sweep in progress).
REQ-010 SHALL have RAM ports: ram_addr  out  ADDR_W; ram_wdata  out  DATA_W; ram_we  out  1; ram_rdata  in  DATA_W (valid 1 cycle after address).
REQ-011 SHALL have port sat_flag  out  1: sticky flag, set when any channel has saturated.

Function
REQ-012 SHALL implement a one-hot FSM with states IDLE, ACQ_RD, ACQ_WAIT, ACQ_WR, HOST_RD, HOST_WAIT, CLEAR; all outputs registered.
REQ-013 SHALL capture clr_req in a pending bit, held until CLEAR is entered.
REQ-014 SHALL arbitrate in IDLE with priorities clear-pending > acq/host; acq vs host is round-robin (last-served loses a tie).
REQ-015 SHALL, on acq grant, pulse acq_ack, latch acq_addr, and run IDLE->ACQ_RD->ACQ_WAIT->ACQ_WR->IDLE.
- ram_we pulses in ACQ_WR with ram_wdata = read+1.
- Each increment takes 4 cycles from grant to return to IDLE.
REQ-016 SHALL NOT increment on a saturated read (all ones): ram_we = 0 in ACQ_WR and sat_flag is set.
REQ-017 SHALL, on host grant, pulse host_ack and latch host_addr, then run IDLE->HOST_RD->HOST_WAIT->IDLE.
- host_rvalid pulses with host_rdata = ram_rdata on exit from HOST_WAIT.
- ram_we stays 0 throughout.
REQ-018 SHALL sweep CLEAR over addresses 0..2^ADDR_W-1, one per cycle, with ram_we = 1, ram_wdata = 0 and clr_busy = 1, then return to IDLE.
- Sweep takes 1024 cycles at default width.
- sat_flag clears on the last write.
REQ-019 SHALL finish any in-progress acq/host transaction before entering CLEAR when clr_req arrives mid-transaction.
REQ-020 SHALL hold requests unacknowledged during CLEAR; requesters keep req high until ack.
REQ-021 SHALL ignore clr_req during CLEAR (no restart).
REQ-022 SHALL treat req as a level: a req held high after ack issues a new request.
REQ-023 SHALL drive ram_we = 0 in every state other than ACQ_WR and CLEAR.

Reset
REQ-024 SHALL, while rst_n = 0, force IDLE and set all outputs, address/data latches, clear counter, pending bit and round-robin pointer to 0 (acq favoured first).
REQ-025 SHALL abort any transaction or sweep on reset with no further RAM write; the RAM is not cleared by reset.

Structure
REQ-026 SHALL place the state encodings and default ADDR_W/DATA_W in a shared package spectrum_pkg, also used by the spectrum acquisition logic.
REQ-027 SHALL implement the two-requester round-robin decision as one sub-module, rr_arb2; all other logic is inline.

Verification
REQ-028 SHALL cover acq increment: RAM[5]=7, acq_req, acq_addr=5 -> acq_ack once; 3 cycles later ram_we=1, ram_addr=5, ram_wdata=8.
REQ-029 SHALL cover saturation: RAM[9]=FFFFFFFF, acq on 9 -> no write, sat_flag=1 until next clear completes.
REQ-030 SHALL cover fairness: acq_req and host_req both held high -> acks alternate acq, host, acq, host; host_rvalid returns RAM[host_addr].
REQ-031 SHALL cover clear during increment: clr_req in ACQ_RD -> the increment write completes, then clr_busy=1 for 1024 cycles writing 0 to addresses 0..1023.
REQ-032 SHALL cover request during clear: acq_req during CLEAR -> no ack until clr_busy falls, then ack in the first IDLE cycle.
REQ-033 SHALL cover reset mid-sweep: rst_n low at address 300 -> ram_we=0 immediately, clr_busy=0, FSM in IDLE after release.
